am29xx_bus_rx_port: RTL and testbench

//  Far-end receiver for the active-low wired-AND transceiver bus: responds to a transmitter driving
//  bus_ with a 4-phase strobe/acknowledge handshake, inverts the bus word to true polarity, and buffers
//  it in a FWFT FIFO for the local side (valid/ready). Sits on each slave card of the open-collector bus.

---
 rtl/am29xx_bus_rx_port_pkg.sv | 17 +
 rtl/am29xx_bus_rx_port_if.sv | 13 +
 rtl/am29xx_sync_fifo.sv | 50 +++++
 rtl/am29xx_bus_rx_port.sv | 90 +++++++++
 tb/tb_am29xx_bus_rx_port.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/am29xx_bus_rx_port_pkg.sv
// Shared types for the am29xx bus receiver: FSM encodings and parity sizing.
// The optional parity bit is controlled by the AM29XX_RX_PARITY_EN macro.
package am29xx_bus_rx_port_pkg;

`ifdef AM29XX_RX_PARITY_EN
  localparam int RX_PAR_BITS = 1;
`else
  localparam int RX_PAR_BITS = 0;
`endif

  typedef enum logic [1:0] {
    RX_SYNC = 2'd0,
    RX_IDLE = 2'd1,
    RX_ACK  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/am29xx_bus_rx_port_if.sv
// Transceiver bus data/strobe bundle; master is the transmitter, slave the receiver card.
// Gains one parity bit when AM29XX_RX_PARITY_EN is defined.
interface am29xx_bus_rx_port_if
  import am29xx_bus_rx_port_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic [WIDTH+RX_PAR_BITS-1:0] bus_;
  logic                         strb_;

  modport master (output bus_, output strb_);
  modport slave  (input  bus_, input  strb_);
endinterface

// File: rtl/am29xx_sync_fifo.sv
// First-word-fall-through register-array FIFO; head reads 0 while empty.
module am29xx_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rptr];

  // NOTE: storage is deliberately not reset; emptiness is defined by the pointers
  // and count, so clearing the array would only add reset fan-out.
  always_ff @(posedge cp) begin
    if (do_push) mem[wptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge cp) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/am29xx_bus_rx_port.sv
// Far-end receiver for the active-low wired-AND bus: 4-phase strobe/ack, inversion, FWFT buffering.
// AM29XX_RX_PARITY_EN adds an odd-parity bit on bus_ and a sticky perr flag.
module am29xx_bus_rx_port
  import am29xx_bus_rx_port_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               cp,
  input  logic               reset,
  am29xx_bus_rx_port_if.slave bus,
  output wire                ack_,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  input  logic               q_ready,
  output logic [AW:0]        count,
  output logic               full,
  output logic               perr
);
  rx_state_e state, state_nxt;
  logic      ack_low;
  logic      capture_en;
  logic      par_ok;
  logic      push;
  logic      empty;
  logic [WIDTH+RX_PAR_BITS-1:0] word_true;

  assign word_true = ~bus.bus_;

`ifdef AM29XX_RX_PARITY_EN
  // Odd parity over data plus parity bit, both in true polarity.
  assign par_ok = ^word_true;

  always_ff @(posedge cp) begin
    if (reset)                      perr <= 1'b0;
    else if (capture_en && !par_ok) perr <= 1'b1;
  end
`else
  assign par_ok = 1'b1;
  assign perr   = 1'b0;
`endif

  always_ff @(posedge cp) begin
    if (reset) state <= RX_SYNC;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_SYNC: if (bus.strb_)              state_nxt = RX_IDLE;
      RX_IDLE: if (!bus.strb_ && !full)    state_nxt = RX_ACK;
      RX_ACK:  if (bus.strb_)              state_nxt = RX_IDLE;
      default:                             state_nxt = RX_SYNC;
    endcase
  end

  // A bad-parity word is still acknowledged so the transmitter never hangs.
  always_comb begin
    ack_low    = 1'b0;
    capture_en = 1'b0;
    case (state)
      RX_IDLE: capture_en = !bus.strb_ && !full;
      RX_ACK:  ack_low    = 1'b1;
      default: ;
    endcase
  end

  assign push    = capture_en && par_ok;
  assign ack_    = ack_low ? 1'b0 : 1'bz;
  assign q_valid = !empty;

  am29xx_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .cp    (cp),
    .reset (reset),
    .push  (push),
    .din   (word_true[WIDTH-1:0]),
    .pop   (q_ready),
    .dout  (q),
    .empty (empty),
    .full  (full),
    .count (count)
  );
endmodule

// File: tb/tb_am29xx_bus_rx_port.sv
// Directed bench for am29xx_bus_rx_port: vector table plus hand sequences for stall/reset corners.
// Parity scenario is compiled in only with AM29XX_RX_PARITY_EN.
module tb_am29xx_bus_rx_port;
  import am29xx_bus_rx_port_pkg::*;

  localparam int WIDTH = 4;
  localparam int BW    = WIDTH + RX_PAR_BITS;

  logic             cp = 1'b0;
  logic             reset;
  logic             q_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [2:0]       count;
  logic             full;
  logic             perr;
  wire              ack_;

  // Open-collector acknowledge: released reads back as 1.
  pullup (ack_);

  am29xx_bus_rx_port_if #(.WIDTH(WIDTH)) bus_if ();

  am29xx_bus_rx_port #(.WIDTH(WIDTH), .DEPTH(4), .AW(2)) dut (
    .cp      (cp),
    .reset   (reset),
    .bus     (bus_if.slave),
    .ack_    (ack_),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .count   (count),
    .full    (full),
    .perr    (perr)
  );

  always #5 cp = ~cp;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  // Bus encoding of a true-polarity word (with correct odd parity when enabled).
  function automatic logic [BW-1:0] enc(input logic [WIDTH-1:0] w);
    logic [BW-1:0] t;
`ifdef AM29XX_RX_PARITY_EN
    t = {~(^w), w};
`else
    t = w;
`endif
    return ~t;
  endfunction

  task automatic drive(input logic strb, input logic [WIDTH-1:0] w);
    bus_if.strb_ = strb;
    bus_if.bus_  = enc(w);
  endtask

  typedef struct {
    logic       rst;
    logic       strb;
    logic [3:0] word;
    logic       rdy;
    logic       ack;
    logic       qv;
    logic [3:0] q;
    logic [2:0] cnt;
    logic       full;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [3:0] exp_q [4];

    // rst strb word rdy | ack qv q cnt full   (ack 1 = released)
    tbl[0]  = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 4'h3, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 4'h3, 3'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 4'h3, 3'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'h3, 3'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 4'h3, 3'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 4'h5, 3'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 4'h9, 3'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};

    reset   = 1'b1;
    q_ready = 1'b0;
    drive(1'b0, 4'h3);

    // Reset with strobe held low, first handshake, push/pop on the same edge.
    for (int i = 0; i < 16; i++) begin
      reset   = tbl[i].rst;
      q_ready = tbl[i].rdy;
      drive(tbl[i].strb, tbl[i].word);
      step();
      check($sformatf("vec%0d_ack", i),     {31'b0, ack_},    {31'b0, tbl[i].ack});
      check($sformatf("vec%0d_qvalid", i),  {31'b0, q_valid}, {31'b0, tbl[i].qv});
      check($sformatf("vec%0d_q", i),       {28'b0, q},       {28'b0, tbl[i].q});
      check($sformatf("vec%0d_count", i),   {29'b0, count},   {29'b0, tbl[i].cnt});
      check($sformatf("vec%0d_full", i),    {31'b0, full},    {31'b0, tbl[i].full});
      check($sformatf("vec%0d_perr", i),    {31'b0, perr},    32'd0);
    end

    // Fill to full with four transfers (pointers wrap from slot 3).
    for (int w = 1; w <= 4; w++) begin
      drive(1'b0, 4'(w));
      step();
      check($sformatf("fill%0d_ack_low", w), {31'b0, ack_}, 32'd0);
      drive(1'b1, 4'(w));
      step();
      check($sformatf("fill%0d_ack_rel", w), {31'b0, ack_}, 32'd1);
    end
    check("fill_count", {29'b0, count}, 32'd4);
    check("fill_full",  {31'b0, full},  32'd1);
    check("fill_head",  {28'b0, q},     32'h1);

    // Fifth strobe stalls while full.
    drive(1'b0, 4'h5);
    step();
    check("stall_ack",   {31'b0, ack_},  32'd1);
    check("stall_count", {29'b0, count}, 32'd4);
    step();
    check("stall2_ack",  {31'b0, ack_},  32'd1);

    // Pop on the same edge as the strobe: capture waits one more edge.
    q_ready = 1'b1;
    step();
    q_ready = 1'b0;
    check("pop_count", {29'b0, count}, 32'd3);
    check("pop_head",  {28'b0, q},     32'h2);
    check("pop_ack",   {31'b0, ack_},  32'd1);
    step();
    check("late_cap_ack",   {31'b0, ack_},  32'd0);
    check("late_cap_count", {29'b0, count}, 32'd4);
    check("late_cap_full",  {31'b0, full},  32'd1);
    drive(1'b1, 4'h5);
    step();
    check("late_cap_rel", {31'b0, ack_}, 32'd1);

    // Drain and confirm order.
    exp_q[0] = 4'h2; exp_q[1] = 4'h3; exp_q[2] = 4'h4; exp_q[3] = 4'h5;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_q", i), {28'b0, q}, {28'b0, exp_q[i]});
      q_ready = 1'b1;
      step();
    end
    q_ready = 1'b0;
    check("drain_count",  {29'b0, count},   32'd0);
    check("drain_qvalid", {31'b0, q_valid}, 32'd0);

    // Reset in the middle of a handshake.
    drive(1'b0, 4'h7);
    step();
    check("mid_ack_low", {31'b0, ack_},  32'd0);
    check("mid_count",   {29'b0, count}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_ack",    {31'b0, ack_},    32'd1);
    check("rst_count",  {29'b0, count},   32'd0);
    check("rst_q",      {28'b0, q},       32'd0);
    check("rst_qvalid", {31'b0, q_valid}, 32'd0);
    step();
    step();
    check("rst_hold_ack",   {31'b0, ack_},  32'd1);
    check("rst_hold_count", {29'b0, count}, 32'd0);
    drive(1'b1, 4'h7);
    step();
    drive(1'b0, 4'hA);
    step();
    check("post_rst_ack", {31'b0, ack_},  32'd0);
    check("post_rst_q",   {28'b0, q},     32'hA);
    check("post_rst_cnt", {29'b0, count}, 32'd1);
    drive(1'b1, 4'hA);
    step();
    check("post_rst_rel", {31'b0, ack_}, 32'd1);

`ifdef AM29XX_RX_PARITY_EN
    // Wrong parity: acknowledged, not stored, perr latched.
    bus_if.strb_ = 1'b0;
    bus_if.bus_  = ~{^4'h6, 4'h6};
    step();
    check("par_bad_ack",   {31'b0, ack_},  32'd0);
    check("par_bad_count", {29'b0, count}, 32'd1);
    check("par_bad_perr",  {31'b0, perr},  32'd1);
    drive(1'b1, 4'h6);
    step();
    drive(1'b0, 4'hC);
    step();
    check("par_good_count", {29'b0, count}, 32'd2);
    check("par_sticky",     {31'b0, perr},  32'd1);
    drive(1'b1, 4'hC);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
